// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the
// valid/ready + redirect port toward the decoder.
// master = fetch unit side, slave = environment (imem + decoder) side.
interface if_fetch_unit_if;
    // Instruction memory
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // Decoder
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] code;
    logic        jCe;
    logic [31:0] jAddr;

    modport master (
        output imem_req, imem_addr, valid, pc, code,
        input  imem_ack, imem_rdata, ready, jCe, jAddr
    );

    modport slave (
        input  imem_req, imem_addr, valid, pc, code,
        output imem_ack, imem_rdata, ready, jCe, jAddr
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a variable
// latency req/ack port, buffers {pc, code} pairs in a small FIFO and hands
// them to the decoder over valid/ready. A decoder redirect (jCe on an
// accepted instruction) flushes the stage and restarts fetch at jAddr.
// Optional: define IF_PERF_CNT_EN to add stall_cnt / redirect_cnt outputs.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt,
`endif
    if_fetch_unit_if.master bus
);

    localparam int unsigned PW       = $clog2(QDEPTH);
    localparam logic [PW:0] LP_DEPTH = (PW + 1)'(QDEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e        r_state;
    state_e        w_state_next;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_next;
    logic [31:0]   r_imem_addr;
    logic [31:0]   w_imem_addr_next;
    logic          w_new_req;

    logic [31:0]   r_fifo_pc   [QDEPTH];
    logic [31:0]   r_fifo_code [QDEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic [PW:0]   w_count_after;

    logic          w_valid;
    logic          w_pop;
    logic          w_redirect;
    logic          w_push;
    logic          w_room;
    logic [31:0]   w_target;

    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid && bus.ready;
    assign w_redirect    = bus.jCe && w_pop;
    assign w_push        = bus.imem_ack && (r_state == StWait) && !w_redirect;
    // Room includes the request about to be issued, so an ack never finds the FIFO full.
    assign w_count_after = r_count - (PW + 1)'(w_pop) + (PW + 1)'(w_push);
    assign w_room        = (w_count_after < LP_DEPTH);
    assign w_target      = {bus.jAddr[31:2], 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_redirect || w_room) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (w_redirect) begin
                    // Outstanding request must still complete; its data is thrown away.
                    w_state_next = bus.imem_ack ? StWait : StDrop;
                end else if (bus.imem_ack) begin
                    w_state_next = w_room ? StWait : StIdle;
                end
            end
            StDrop: begin
                // Without an ack a redirect only retargets fetch_pc and we keep draining.
                if (bus.imem_ack) begin
                    w_state_next = (w_redirect || w_room) ? StWait : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs toward memory and decoder
    always_comb begin
        bus.imem_req  = (r_state != StIdle);
        bus.imem_addr = r_imem_addr;
        bus.valid     = w_valid;
        bus.pc        = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
        bus.code      = w_valid ? r_fifo_code[r_rd_ptr] : 32'h0;
    end

    // Next fetch address; a new request is launched whenever we enter WAIT
    // without a request still outstanding.
    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (w_redirect) begin
            w_fetch_pc_next = w_target;
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + 32'd4;
        end
        w_new_req        = (w_state_next == StWait) && ((r_state != StWait) || bus.imem_ack);
        w_imem_addr_next = w_new_req ? w_fetch_pc_next : r_imem_addr;
    end

    // PC and request address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_imem_addr <= RESET_PC;
        end else begin
            r_fetch_pc  <= w_fetch_pc_next;
            r_imem_addr <= w_imem_addr_next;
        end
    end

    // FIFO pointers and occupancy; a redirect consumes the head and flushes the rest
    always_ff @(posedge clk) begin
        if (rst || w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_after;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_imem_addr;
            r_fifo_code[r_wr_ptr] <= bus.imem_rdata;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_redirect_cnt;

    // Decoder back-pressure cycles and taken redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt    <= 32'h0;
            r_redirect_cnt <= 32'h0;
        end else begin
            if (w_valid && !bus.ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_redirect) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit (RESET_PC=0, QDEPTH=2) with a
// variable-latency instruction memory model answering on the falling edge.
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mem_lat = 1;
    int   mem_wait = 0;

    if_fetch_unit_if bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] redirect_cnt;
`endif

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
`ifdef IF_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1234_5678 ^ {a[15:0], a[31:16]};
    endfunction

    // Memory acks the mem_lat-th falling edge of an outstanding request
    always @(negedge clk) begin
        if (bus.imem_req === 1'b1) begin
            if (mem_wait >= mem_lat - 1) begin
                bus.imem_ack   <= 1'b1;
                bus.imem_rdata <= mem_word(bus.imem_addr);
                mem_wait       <= 0;
            end else begin
                bus.imem_ack   <= 1'b0;
                bus.imem_rdata <= 32'hDEAD_BEEF;
                mem_wait       <= mem_wait + 1;
            end
        end else begin
            bus.imem_ack   <= 1'b0;
            bus.imem_rdata <= 32'hDEAD_BEEF;
            mem_wait       <= 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.ready = 1'b0;
        bus.jCe   = 1'b0;
        bus.jAddr = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_valid", {31'h0, bus.valid}, 32'h0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_code", bus.code, 32'h0);
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'h0);
        chk("rst_redir_cnt", redirect_cnt, 32'h0);
`endif

        // Single-cycle memory, decoder always ready: one instruction per cycle
        mem_lat   = 1;
        bus.ready = 1'b1;
        rst       = 1'b0;
        step();
        chk("t1_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t1_addr0", bus.imem_addr, 32'h0);
        chk("t1_valid0", {31'h0, bus.valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_valid", {31'h0, bus.valid}, 32'h1);
            chk("t1_pc", bus.pc, 32'(4 * i));
            chk("t1_code", bus.code, mem_word(32'(4 * i)));
            chk("t1_addr", bus.imem_addr, 32'(4 * i + 4));
        end

        // Three-cycle memory latency: address held 3 cycles, one instr every 3 cycles
        mem_lat = 3;
        do_reset();
        step();
        chk("t2_addr0", bus.imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_gap_valid", {31'h0, bus.valid}, 32'h0);
            chk("t2_gap_addr", bus.imem_addr, 32'(4 * i));
            step();
            chk("t2_gap_valid", {31'h0, bus.valid}, 32'h0);
            chk("t2_gap_addr", bus.imem_addr, 32'(4 * i));
            step();
            chk("t2_valid", {31'h0, bus.valid}, 32'h1);
            chk("t2_pc", bus.pc, 32'(4 * i));
            chk("t2_code", bus.code, mem_word(32'(4 * i)));
            chk("t2_addr", bus.imem_addr, 32'(4 * i + 4));
        end

        // Head pc=8, fetch of 12 outstanding: redirect to 0x43 goes through DROP
        bus.jCe   = 1'b1;
        bus.jAddr = 32'h0000_0043;
        step();
        bus.jCe = 1'b0;
        chk("t4_valid_after_redir", {31'h0, bus.valid}, 32'h0);
        chk("t4_drop_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t4_drop_addr", bus.imem_addr, 32'h0000_000C);
`ifdef IF_PERF_CNT_EN
        chk("t4_redir_cnt", redirect_cnt, 32'h1);
`endif
        step();
        chk("t4_drop_hold_addr", bus.imem_addr, 32'h0000_000C);
        chk("t4_drop_hold_valid", {31'h0, bus.valid}, 32'h0);
        step();
        chk("t4_new_addr", bus.imem_addr, 32'h0000_0040);
        chk("t4_new_valid", {31'h0, bus.valid}, 32'h0);
        step();
        chk("t4_no_stale_a", {31'h0, bus.valid}, 32'h0);
        step();
        chk("t4_no_stale_b", {31'h0, bus.valid}, 32'h0);
        step();
        chk("t4_tgt_valid", {31'h0, bus.valid}, 32'h1);
        chk("t4_tgt_pc", bus.pc, 32'h0000_0040);
        chk("t4_tgt_code", bus.code, mem_word(32'h0000_0040));

        // Decoder stalled 10 cycles with jCe high (ignored): exactly two entries buffered
        mem_lat   = 1;
        bus.ready = 1'b0;
        bus.jCe   = 1'b1;
        bus.jAddr = 32'h0000_0200;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
        end
        chk("t3_full_valid", {31'h0, bus.valid}, 32'h1);
        chk("t3_full_pc", bus.pc, 32'h0);
        chk("t3_full_code", bus.code, mem_word(32'h0));
        chk("t3_full_req", {31'h0, bus.imem_req}, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("t3_stall_cnt", stall_cnt, 32'd8);
        chk("t3_redir_cnt", redirect_cnt, 32'h0);
`endif
        bus.jCe   = 1'b0;
        bus.ready = 1'b1;
        step();
        chk("t3_drain_pc4", bus.pc, 32'h4);
        chk("t3_drain_code4", bus.code, mem_word(32'h4));
        chk("t3_refetch_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t3_refetch_addr", bus.imem_addr, 32'h8);
        step();
        chk("t3_drain_pc8", bus.pc, 32'h8);
        chk("t3_drain_code8", bus.code, mem_word(32'h8));

        // Redirect coinciding with ack; target low bits masked, fetch_pc wraps
        bus.jCe = 1'b0;
        do_reset();
        step();
        step();
        step();
        chk("t5_pre_pc", bus.pc, 32'h4);
        bus.jCe   = 1'b1;
        bus.jAddr = 32'hFFFF_FFFE;
        step();
        bus.jCe = 1'b0;
        chk("t5_valid_after_redir", {31'h0, bus.valid}, 32'h0);
        chk("t5_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
`ifdef IF_PERF_CNT_EN
        chk("t5_redir_cnt", redirect_cnt, 32'h1);
`endif
        step();
        chk("t5_tgt_pc", bus.pc, 32'hFFFF_FFFC);
        chk("t5_tgt_code", bus.code, mem_word(32'hFFFF_FFFC));
        chk("t5_wrap_addr", bus.imem_addr, 32'h0);
        step();
        chk("t5_wrap_pc", bus.pc, 32'h0);
        chk("t5_wrap_code", bus.code, mem_word(32'h0));
        chk("t5_wrap_next_addr", bus.imem_addr, 32'h4);

        // Reset while WAIT with an ack arriving the same cycle
        do_reset();
        step();
        step();
        step();
        chk("t6_pre_addr", bus.imem_addr, 32'h8);
        rst = 1'b1;
        step();
        chk("t6_valid", {31'h0, bus.valid}, 32'h0);
        chk("t6_pc", bus.pc, 32'h0);
        chk("t6_code", bus.code, 32'h0);
        chk("t6_req", {31'h0, bus.imem_req}, 32'h0);
        chk("t6_addr", bus.imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("t6_stall_cnt", stall_cnt, 32'h0);
        chk("t6_redir_cnt", redirect_cnt, 32'h0);
`endif
        rst = 1'b0;
        step();
        chk("t6_restart_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t6_restart_addr", bus.imem_addr, 32'h0);
        step();
        chk("t6_restart_pc", bus.pc, 32'h0);
        chk("t6_restart_valid", {31'h0, bus.valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
